// File: rtl/result_pack_pkg.sv
// Shared constants for the result packer: config address map and counter width.
package result_pack_pkg;

  // Config address map; CFG_PACK sits next to the layers block's entry.
  localparam int CFG_LAYERS = 1;
  localparam int CFG_PACK   = 2;

  // Width of the remaining-beat counter (beat count field of the config word).
  localparam int REM_W = 16;

endpackage

// File: rtl/result_pack_if.sv
// Result beat input stream and packed store output stream of result_pack.
interface result_pack_if #(
  parameter int BEAT_W  = 16,
  parameter int PACK_NB = 4
);
  logic [BEAT_W-1:0]         result_bus;
  logic                      result_val;
  logic                      result_rdy;
  logic [PACK_NB*BEAT_W-1:0] str_data;
  logic [PACK_NB-1:0]        str_keep;
  logic                      str_last;
  logic                      str_val;
  logic                      str_rdy;

  // Packer side.
  modport slave (
    input  result_bus, result_val, str_rdy,
    output result_rdy, str_data, str_keep, str_last, str_val
  );

  // Producer of beats / consumer of store words.
  modport master (
    output result_bus, result_val, str_rdy,
    input  result_rdy, str_data, str_keep, str_last, str_val
  );
endinterface

// File: rtl/result_pack.sv
// result_pack: packs PACK_NB result beats into one store word per transfer of
// N beats; the final word may be partial (keep bits) and carries str_last.
// Optional macro RESULT_PACK_STATS_EN adds the stat_words accepted-word counter.
//
// state | meaning
// IDLE  | waiting for a CFG_PACK write with N != 0
// FILL  | accepting beats, emitting a word every PACK_NB beats or on the last one
// DRAIN | last word loaded, waiting for it to leave the output register
module result_pack
  import result_pack_pkg::*;
#(
  parameter int DEPTH_NB   = 1,
  parameter int IMG_WIDTH  = 16,
  parameter int PACK_NB    = 4,
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  result_pack_if.slave          io,
`ifdef RESULT_PACK_STATS_EN
  output logic [31:0]           stat_words,
`endif
  output logic                  busy
);

  localparam int BEAT_W = IMG_WIDTH * DEPTH_NB;
  localparam int WORD_W = PACK_NB * BEAT_W;
  localparam int LANE_W = (PACK_NB > 1) ? $clog2(PACK_NB) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [LANE_W-1:0]  lane;
  logic [REM_W-1:0]   rem;
  logic [WORD_W-1:0]  pack_reg;
  logic [WORD_W-1:0]  merged;
  logic [PACK_NB-1:0] keep_nxt;
  logic [WORD_W-1:0]  out_data;
  logic [PACK_NB-1:0] out_keep;
  logic               out_last;
  logic               out_val;
  logic               rdy;
  logic               accept;
  logic               complete;
  logic               last_beat;
  logic               cfg_hit;

  assign cfg_hit   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_PACK)) &&
                     (cfg_data[15:0] != 16'd0);
  assign accept    = io.result_val && rdy;
  assign last_beat = (rem == REM_W'(1));
  assign complete  = (lane == LANE_W'(PACK_NB - 1)) || last_beat;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and beat-side ready.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      IDLE:  if (cfg_hit) state_nxt = FILL;
      FILL: begin
        rdy = !out_val || io.str_rdy;
        if (accept && complete && last_beat) state_nxt = DRAIN;
      end
      DRAIN: if (!out_val || io.str_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pack register with the incoming beat dropped into the current lane, and keep mask.
  always_comb begin
    merged   = pack_reg;
    keep_nxt = '0;
    for (int i = 0; i < PACK_NB; i++) begin
      if (lane == LANE_W'(i)) merged[i*BEAT_W +: BEAT_W] = io.result_bus;
      keep_nxt[i] = (lane >= LANE_W'(i));
    end
  end

  // Lane/remaining counters, pack register and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane     <= '0;
      rem      <= '0;
      pack_reg <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      out_val  <= 1'b0;
    end else begin
      if (state == IDLE && cfg_hit) begin
        rem      <= cfg_data[15:0];
        lane     <= '0;
        pack_reg <= '0;
      end
      if (accept) begin
        rem <= rem - REM_W'(1);
        if (complete) begin
          lane     <= '0;
          pack_reg <= '0;
        end else begin
          lane     <= lane + LANE_W'(1);
          pack_reg <= merged;
        end
      end
      // rdy already guarantees the output register is empty or emptying here.
      if (accept && complete) begin
        out_data <= merged;
        out_keep <= keep_nxt;
        out_last <= last_beat;
        out_val  <= 1'b1;
      end else if (out_val && io.str_rdy) begin
        out_val <= 1'b0;
      end
    end
  end

`ifdef RESULT_PACK_STATS_EN
  // Count of store words taken downstream; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst)                        stat_words <= '0;
    else if (out_val && io.str_rdy)  stat_words <= stat_words + 32'd1;
  end
`endif

  assign io.result_rdy = rdy;
  assign io.str_data   = out_data;
  assign io.str_keep   = out_keep;
  assign io.str_last   = out_last;
  assign io.str_val    = out_val;
  assign busy          = (state != IDLE) || out_val;

endmodule

// File: tb/tb_result_pack.sv
// Scoreboard bench for result_pack (PACK_NB=4, 16-bit beats).
module tb_result_pack;
  import result_pack_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic        busy;
`ifdef RESULT_PACK_STATS_EN
  logic [31:0] stat_words;
`endif

  int n_cmp = 0;
  int n_err = 0;
  word_t sb[$];

  result_pack_if #(.BEAT_W(16), .PACK_NB(4)) bus ();

  result_pack #(
    .DEPTH_NB(1), .IMG_WIDTH(16), .PACK_NB(4), .CFG_DWIDTH(32), .CFG_AWIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .io(bus),
`ifdef RESULT_PACK_STATS_EN
    .stat_words(stat_words),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d; w.keep = k; w.last = l;
    sb.push_back(w);
  endtask

  // Monitor: compare every word that is taken downstream against the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.str_val && bus.str_rdy) begin
      word_t w;
      if (sb.size() == 0) begin
        check("unexpected_word", bus.str_data, 64'hx);
      end else begin
        w = sb.pop_front();
        check("word_data", bus.str_data, w.data);
        check("word_keep", {60'd0, bus.str_keep}, {60'd0, w.keep});
        check("word_last", {63'd0, bus.str_last}, {63'd0, w.last});
      end
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] n);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = {16'd0, n};
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic send_beat(input logic [15:0] v);
    int t;
    t = 0;
    bus.result_val = 1'b1;
    bus.result_bus = v;
    @(negedge clk);
    while (!bus.result_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("beat_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    bus.result_val = 1'b0;
    bus.result_bus = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_rdy", {63'd0, bus.result_rdy}, 64'd0);
  endtask

  initial begin
    int t;
    bus.result_val = 1'b0;
    bus.result_bus = '0;
    bus.str_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_val", {63'd0, bus.str_val}, 64'd0);
    check("rst_rdy", {63'd0, bus.result_rdy}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // N=8, beats 1..8, two full words.
    expect_word(64'h0004_0003_0002_0001, 4'hf, 1'b0);
    expect_word(64'h0008_0007_0006_0005, 4'hf, 1'b1);
    cfg_write(5'(CFG_PACK), 16'd8);
    for (int i = 1; i <= 8; i++) send_beat(16'(i));
    wait_idle();

    // N=6, last word partial.
    expect_word(64'h0004_0003_0002_0001, 4'hf, 1'b0);
    expect_word(64'h0000_0000_0006_0005, 4'h3, 1'b1);
    cfg_write(5'(CFG_PACK), 16'd6);
    for (int i = 1; i <= 6; i++) send_beat(16'(i));
    wait_idle();
`ifdef RESULT_PACK_STATS_EN
    check("stat_words", {32'd0, stat_words}, 64'd4);
`endif

    // Downstream stall after the first word.
    expect_word(64'h0034_0033_0032_0031, 4'hf, 1'b0);
    expect_word(64'h0038_0037_0036_0035, 4'hf, 1'b1);
    bus.str_rdy = 1'b0;
    cfg_write(5'(CFG_PACK), 16'd8);
    for (int i = 1; i <= 4; i++) send_beat(16'h30 + 16'(i));
    bus.result_val = 1'b1;
    bus.result_bus = 16'h35;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rdy", {63'd0, bus.result_rdy}, 64'd0);
      check("stall_data", bus.str_data, 64'h0034_0033_0032_0031);
    end
    @(posedge clk); #1;
    bus.str_rdy = 1'b1;
    send_beat(16'h35);
    for (int i = 6; i <= 8; i++) send_beat(16'h30 + 16'(i));
    wait_idle();

    // Zero-length and foreign-address configs are ignored.
    cfg_write(5'(CFG_PACK), 16'd0);
    @(negedge clk);
    check("n0_rdy", {63'd0, bus.result_rdy}, 64'd0);
    check("n0_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    cfg_write(5'd7, 16'd4);
    @(negedge clk);
    check("addr_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Reconfig written mid-FILL is ignored.
    expect_word(64'h0024_0023_0022_0021, 4'hf, 1'b0);
    expect_word(64'h0028_0027_0026_0025, 4'hf, 1'b1);
    cfg_write(5'(CFG_PACK), 16'd8);
    send_beat(16'h21);
    send_beat(16'h22);
    cfg_write(5'(CFG_PACK), 16'd4);
    for (int i = 3; i <= 8; i++) send_beat(16'h20 + 16'(i));
    wait_idle();

    // Reset after 3 beats discards the partial transfer.
    cfg_write(5'(CFG_PACK), 16'd8);
    for (int i = 1; i <= 3; i++) send_beat(16'h40 + 16'(i));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_val", {63'd0, bus.str_val}, 64'd0);
    check("mrst_data", bus.str_data, 64'd0);
    check("mrst_keep", {60'd0, bus.str_keep}, 64'd0);
    check("mrst_rdy", {63'd0, bus.result_rdy}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_word(64'h000c_000b_000a_0009, 4'hf, 1'b1);
    cfg_write(5'(CFG_PACK), 16'd4);
    for (int i = 9; i <= 12; i++) send_beat(16'(i));
    wait_idle();

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
